// File: rtl/dmux_pkg.sv
// Shared definitions for the 4-way 16-bit stream demultiplexer.
//   DATA_WIDTH : default data width of the input word and every output slot
//   NUM_OUT    : number of output slots (a, b, c, d)
//   SEL_A..D   : target encodings carried on sel / rr_ptr
//   decode_tgt : 2-to-4 one-hot decode of a target encoding
package dmux_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned NUM_OUT    = 4;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  function automatic logic [NUM_OUT-1:0] decode_tgt(input logic [1:0] tgt);
    logic [NUM_OUT-1:0] oh;
    oh = '0;
    case (tgt)
      SEL_A:   oh = 4'b0001;
      SEL_B:   oh = 4'b0010;
      SEL_C:   oh = 4'b0100;
      SEL_D:   oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dmux4way16_stream_out_slot.sv
// One-entry registered output slot with valid/ready drain.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : write wr_data into the slot on the next edge
//   wr_data   : word to store
//   rd_ready  : consumer takes the held word this cycle
//   data      : held word (keeps last value after a drain)
//   valid     : slot holds an unconsumed word
//   can_write : slot is empty or being drained this cycle
module out_slot
  import dmux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             can_write
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && rd_ready) begin
      valid_d = 1'b0;
    end
    // A write in the same cycle as a drain wins, keeping the slot valid.
    if (wr_en) begin
      data_d  = wr_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign can_write = ~valid_q | rd_ready;

endmodule

// File: rtl/dmux4way16_stream.sv
// Sequential 1-to-4 demultiplexer with valid/ready handshakes.
// One accepted input word is routed to slot a/b/c/d, chosen by sel or by
// a round-robin pointer when auto=1.
//   clk, rst        : clock, synchronous active-high reset
//   in_data/valid   : producer word and offer
//   in_ready        : target slot can take a word this cycle (combinational)
//   sel, auto       : explicit target, or round-robin when auto=1
//   a, b, c, d      : registered slot data
//   out_valid/ready : per-slot handshake, bit0=a .. bit3=d
//   rr_ptr          : current round-robin target
//   count           : total accepted words (wraps)
module dmux4way16_stream
  import dmux_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         sel,
  input  logic               auto,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   d,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [1:0]         rr_ptr,
  output logic [CNT_W-1:0]   count
);

  logic [1:0]         tgt;
  logic [NUM_OUT-1:0] tgt_oh;
  logic [NUM_OUT-1:0] slot_can_write;
  logic [NUM_OUT-1:0] slot_wr_en;
  logic               accept;
  logic [WIDTH-1:0]   slot_data [NUM_OUT];

  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  always_comb begin
    tgt        = auto ? rr_ptr_q : sel;
    tgt_oh     = decode_tgt(tgt);
    // Only the targeted slot gates the producer; other full slots never block.
    in_ready   = slot_can_write[tgt];
    accept     = in_valid & in_ready & ~rst;
    slot_wr_en = accept ? tgt_oh : '0;

    rr_ptr_d = rr_ptr_q;
    count_d  = count_q;
    if (accept) begin
      count_d = count_q + CNT_W'(1);
      if (auto) begin
        rr_ptr_d = rr_ptr_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < int'(NUM_OUT); gi++) begin : g_slot
    out_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (slot_wr_en[gi]),
      .wr_data  (in_data),
      .rd_ready (out_ready[gi]),
      .data     (slot_data[gi]),
      .valid    (out_valid[gi]),
      .can_write(slot_can_write[gi])
    );
  end

  assign a      = slot_data[0];
  assign b      = slot_data[1];
  assign c      = slot_data[2];
  assign d      = slot_data[3];
  assign rr_ptr = rr_ptr_q;
  assign count  = count_q;

endmodule

// File: tb/tb_dmux4way16_stream.sv
module tb_dmux4way16_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic        auto;
  logic [15:0] a, b, c, d;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [1:0]  rr_ptr;
  logic [15:0] count;

  int total = 0;
  int bad   = 0;

  // Reference model: per-slot scoreboard queue (depth 0 or 1), last data,
  // round-robin pointer and accepted-word counter.
  logic [15:0] exp_q [4][$];
  logic [15:0] m_last [4];
  logic [1:0]  m_rr;
  logic [15:0] m_count;

  dmux4way16_stream #(
    .WIDTH(16),
    .CNT_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .auto     (auto),
    .a        (a),
    .b        (b),
    .c        (c),
    .d        (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .rr_ptr   (rr_ptr),
    .count    (count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] slot_val(input int i);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  // Inputs change at negedge+1; DUT state after each edge is visible then.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor: samples at negedge+2, checks current state against
  // the model, then advances the model to what the next edge should produce.
  always @(negedge clk) begin
    logic [1:0]  tgt;
    logic        exp_rdy;
    logic [15:0] w;
    #2;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid[i] !== (exp_q[i].size() != 0)) begin
        bad++;
        $display("FAIL mon_valid[%0d]: got %b expected %b", i, out_valid[i], exp_q[i].size() != 0);
      end
      total++;
      if (slot_val(i) !== m_last[i]) begin
        bad++;
        $display("FAIL mon_data[%0d]: got %h expected %h", i, slot_val(i), m_last[i]);
      end
    end
    total++;
    if (rr_ptr !== m_rr) begin
      bad++;
      $display("FAIL mon_rr: got %b expected %b", rr_ptr, m_rr);
    end
    total++;
    if (count !== m_count) begin
      bad++;
      $display("FAIL mon_count: got %0d expected %0d", count, m_count);
    end
    tgt     = auto ? m_rr : sel;
    exp_rdy = (exp_q[tgt].size() == 0) || out_ready[tgt];
    total++;
    if (in_ready !== exp_rdy) begin
      bad++;
      $display("FAIL mon_in_ready: got %b expected %b", in_ready, exp_rdy);
    end

    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        m_last[i] = '0;
      end
      m_rr    = '0;
      m_count = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (exp_q[i].size() != 0 && out_ready[i]) begin
          w = exp_q[i].pop_front();
          total++;
          if (slot_val(i) !== w) begin
            bad++;
            $display("FAIL pop[%0d]: got %h expected %h", i, slot_val(i), w);
          end
        end
      end
      if (in_valid && exp_rdy) begin
        exp_q[tgt].push_back(in_data);
        m_last[tgt] = in_data;
        m_count++;
        if (auto) m_rr++;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 16'hFFFF;
    sel = 2'b00; auto = 1'b0; out_ready = 4'b0000;
    cyc();
    cyc();
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready_during: got %b expected 1", in_ready); end
    rst = 1'b0; in_valid = 1'b0;
    cyc();
    total++;
    if ({a, b, c, d} !== 64'h0) begin bad++; $display("FAIL reset_data: got %h expected 0", {a, b, c, d}); end
    total++;
    if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid: got %b expected 0000", out_valid); end
    total++;
    if (count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d expected 0", count); end
    total++;
    if (rr_ptr !== 2'b00) begin bad++; $display("FAIL reset_rr: got %b expected 00", rr_ptr); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_explicit();
    logic [15:0] words [4];
    words = '{16'hAAAA, 16'h5555, 16'h0F0F, 16'hF0F0};
    auto = 1'b0; out_ready = 4'b1111;
    in_valid = 1'b1; in_data = words[0]; sel = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      total++;
      if (out_valid !== (4'b0001 << i)) begin bad++; $display("FAIL explicit_valid%0d: got %b expected %b", i, out_valid, 4'b0001 << i); end
      total++;
      if (slot_val(i) !== words[i]) begin bad++; $display("FAIL explicit_data%0d: got %h expected %h", i, slot_val(i), words[i]); end
      if (i < 3) begin
        in_data = words[i+1]; sel = 2'(i + 1);
      end else begin
        in_valid = 1'b0;
      end
    end
    cyc();
    total++;
    if (out_valid !== 4'b0000) begin bad++; $display("FAIL explicit_drained: got %b expected 0000", out_valid); end
    total++;
    if (count !== 16'd4) begin bad++; $display("FAIL explicit_count: got %0d expected 4", count); end
  endtask

  task automatic test_backpressure();
    auto = 1'b0; out_ready = 4'b0000; sel = 2'b01;
    in_valid = 1'b1; in_data = 16'h1234;
    cyc();
    total++;
    if (b !== 16'h1234 || out_valid !== 4'b0010) begin bad++; $display("FAIL bp_first: got b=%h v=%b expected 1234/0010", b, out_valid); end
    in_data = 16'h5678;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_blocked: got %b expected 0", in_ready); end
    cyc();
    total++;
    if (b !== 16'h1234 || out_valid !== 4'b0010) begin bad++; $display("FAIL bp_hold: got b=%h v=%b expected 1234/0010", b, out_valid); end
    out_ready = 4'b0010;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release: got %b expected 1", in_ready); end
    cyc();
    total++;
    if (b !== 16'h5678 || out_valid !== 4'b0010) begin bad++; $display("FAIL bp_refill: got b=%h v=%b expected 5678/0010", b, out_valid); end
    in_valid = 1'b0; out_ready = 4'b1111;
    cyc();
    total++;
    if (out_valid !== 4'b0000 || count !== 16'd6) begin bad++; $display("FAIL bp_end: got v=%b count=%0d expected 0000/6", out_valid, count); end
  endtask

  task automatic test_round_robin();
    auto = 1'b1; out_ready = 4'b1111; sel = 2'b11;
    in_valid = 1'b1; in_data = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      cyc();
      total++;
      if (slot_val(i % 4) !== 16'(i + 1) || out_valid !== (4'b0001 << (i % 4))) begin
        bad++;
        $display("FAIL rr_route%0d: got data=%h v=%b expected %h/%b", i, slot_val(i % 4), out_valid, 16'(i + 1), 4'b0001 << (i % 4));
      end
      if (i < 4) in_data = 16'(i + 2);
      else       in_valid = 1'b0;
    end
    total++;
    if (rr_ptr !== 2'b01) begin bad++; $display("FAIL rr_ptr_end: got %b expected 01", rr_ptr); end
    total++;
    if (count !== 16'd11) begin bad++; $display("FAIL rr_count: got %0d expected 11", count); end
  endtask

  task automatic test_stall();
    auto = 1'b1; out_ready = 4'b1111; in_valid = 1'b1; in_data = 16'hBBBB;
    cyc();
    total++;
    if (rr_ptr !== 2'b10 || b !== 16'hBBBB) begin bad++; $display("FAIL stall_setup: got rr=%b b=%h expected 10/bbbb", rr_ptr, b); end
    in_valid = 1'b0;
    cyc();
    out_ready = 4'b0000; auto = 1'b0; sel = 2'b10; in_valid = 1'b1; in_data = 16'hCCCC;
    cyc();
    total++;
    if (out_valid !== 4'b0100 || c !== 16'hCCCC || rr_ptr !== 2'b10) begin
      bad++; $display("FAIL stall_fill_c: got v=%b c=%h rr=%b expected 0100/cccc/10", out_valid, c, rr_ptr);
    end
    auto = 1'b1; in_data = 16'hDDDD;
    #1;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_no_skip: got %b expected 0", in_ready); end
    cyc();
    total++;
    if (rr_ptr !== 2'b10 || c !== 16'hCCCC || out_valid !== 4'b0100) begin
      bad++; $display("FAIL stall_hold: got rr=%b c=%h v=%b expected 10/cccc/0100", rr_ptr, c, out_valid);
    end
    auto = 1'b0; sel = 2'b00;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL stall_mode_switch: got %b expected 1", in_ready); end
    cyc();
    total++;
    if (a !== 16'hDDDD || out_valid !== 4'b0101 || rr_ptr !== 2'b10) begin
      bad++; $display("FAIL stall_land_a: got a=%h v=%b rr=%b expected dddd/0101/10", a, out_valid, rr_ptr);
    end
    in_valid = 1'b0; out_ready = 4'b1111;
    cyc();
    total++;
    if (out_valid !== 4'b0000 || count !== 16'd14) begin bad++; $display("FAIL stall_end: got v=%b count=%0d expected 0000/14", out_valid, count); end
  endtask

  task automatic test_count_wrap();
    rst = 1'b1; in_valid = 1'b0;
    cyc();
    rst = 1'b0; auto = 1'b0; sel = 2'b00; out_ready = 4'b1111; in_valid = 1'b1;
    for (int n = 0; n < 65535; n++) begin
      in_data = 16'(n);
      cyc();
    end
    total++;
    if (count !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre: got %0d expected 65535", count); end
    in_data = 16'hBEEF;
    cyc();
    total++;
    if (count !== 16'd0 || a !== 16'hBEEF) begin bad++; $display("FAIL wrap: got count=%0d a=%h expected 0/beef", count, a); end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_reset_mid();
    out_ready = 4'b0000; auto = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i); in_data = 16'hA0A0 + 16'(i);
      cyc();
    end
    total++;
    if (out_valid !== 4'b1111 || d !== 16'hA0A3) begin bad++; $display("FAIL mid_full: got v=%b d=%h expected 1111/a0a3", out_valid, d); end
    rst = 1'b1; in_data = 16'hFFFF; sel = 2'b01; out_ready = 4'b0010;
    cyc();
    total++;
    if (out_valid !== 4'b0000) begin bad++; $display("FAIL mid_valid: got %b expected 0000", out_valid); end
    total++;
    if ({a, b, c, d} !== 64'h0 || count !== 16'd0 || rr_ptr !== 2'b00) begin
      bad++; $display("FAIL mid_state: got data=%h count=%0d rr=%b expected 0/0/00", {a, b, c, d}, count, rr_ptr);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    cyc();
    total++;
    if (out_valid !== 4'b0000) begin bad++; $display("FAIL mid_after: got %b expected 0000", out_valid); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_last[i] = '0;
    m_rr    = '0;
    m_count = '0;
    test_reset();
    test_explicit();
    test_backpressure();
    test_round_robin();
    test_stall();
    test_count_wrap();
    test_reset_mid();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
